// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package rv_pkg;

  localparam int unsigned CNT_W = 5;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fix-up at the end, result held until the register-file write is accepted.
module rv_muldiv
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_rs1_data_i,
  input  logic [XLEN-1:0] req_rs2_data_i,
  input  logic [4:0]      req_rd_addr_i,
  input  logic            flush_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            busy_o
);

  localparam int unsigned AW = XLEN + 2;

  muldiv_state_e   state_q;
  muldiv_op_e      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic [XLEN-1:0] res_q;

  muldiv_op_e      req_op;
  logic            a_neg, b_neg, req_neg;
  logic            b_zero, div_ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  logic [AW-1:0]   add_x, add_y, add_s;
  logic            add_sub;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] div_val, done_res;

  assign req_op = muldiv_op_e'(req_op_i);

  // Request decode: magnitudes, result sign and divide special cases.
  always_comb begin
    a_neg    = req_rs1_data_i[XLEN-1] & (req_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    b_neg    = req_rs2_data_i[XLEN-1] & (req_op inside {OP_MULH, OP_DIV, OP_REM});
    a_mag    = a_neg ? -req_rs1_data_i : req_rs1_data_i;
    b_mag    = b_neg ? -req_rs2_data_i : req_rs2_data_i;
    req_neg  = a_neg ^ (b_neg & (req_op != OP_REM));
    b_zero   = (req_rs2_data_i == '0);
    div_ovf  = (req_op inside {OP_DIV, OP_REM}) && (req_rs1_data_i == INT_MIN) &&
               (req_rs2_data_i == '1);
    fast     = req_op_i[2] && (b_zero || div_ovf);
    fast_res = '0;
    if (req_op_i[1]) begin
      fast_res = b_zero ? req_rs1_data_i : '0;
    end else begin
      fast_res = b_zero ? DIV_BY_ZERO_Q : INT_MIN;
    end
  end

  // Shared adder: accumulate in MUL, trial subtract in DIV.
  always_comb begin
    add_sub = (state_q == DIV);
    add_x   = {2'b00, hi_q};
    add_y   = '0;
    if (add_sub) begin
      add_x = {1'b0, hi_q, lo_q[XLEN-1]};
      add_y = ~{2'b00, b_q};
    end else if (lo_q[0]) begin
      add_y = {2'b00, a_q};
    end
    add_s = add_x + add_y + AW'(add_sub);
  end

  // One iteration step and the final signed result selection.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == DIV) begin
      hi_d = add_s[AW-1] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : add_s[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~add_s[AW-1]};
    end else begin
      hi_d = add_s[XLEN:1];
      lo_d = {add_s[0], lo_q[XLEN-1:1]};
    end

    prod = {hi_d, lo_d};
    if (neg_q) prod = -prod;
    div_val = (op_q inside {OP_DIV, OP_DIVU}) ? lo_d : hi_d;
    if (neg_q) div_val = -div_val;

    if (state_q == DIV) begin
      done_res = div_val;
    end else if (op_q == OP_MUL) begin
      done_res = prod[XLEN-1:0];
    end else begin
      done_res = prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            op_q  <= req_op;
            rd_q  <= req_rd_addr_i;
            neg_q <= req_neg;
            cnt_q <= '0;
            a_q   <= a_mag;
            b_q   <= b_mag;
            hi_q  <= '0;
            lo_q  <= req_op_i[2] ? a_mag : b_mag;
            if (fast) begin
              res_q   <= fast_res;
              state_q <= DONE;
            end else begin
              state_q <= req_op_i[2] ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            res_q   <= done_res;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // rd==0 results are discarded after a single DONE cycle
          if ((rd_q == '0) || wb_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE) && !flush_i;
  assign busy_o       = (state_q != IDLE);
  assign wb_valid_o   = (state_q == DONE) && (rd_q != '0);
  assign wb_rd_addr_o = rd_q;
  assign wb_data_o    = res_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Directed bench for rv_muldiv: arithmetic reference model plus per-cycle handshake checks.
module tb_rv_muldiv;
  import rv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [31:0] req_rs1_data_i;
  logic [31:0] req_rs2_data_i;
  logic [4:0]  req_rd_addr_i;
  logic        flush_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference state: one outstanding op, its due cycle and result
  bit          m_pend = 1'b0;
  int          m_due  = 0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;

  rv_muldiv #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_rs1_data_i (req_rs1_data_i),
    .req_rs2_data_i (req_rs2_data_i),
    .req_rd_addr_i  (req_rd_addr_i),
    .flush_i        (flush_i),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_rd_addr_o   (wb_rd_addr_o),
    .wb_data_o      (wb_data_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p, ua64, ub64;
    logic [31:0] r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'd0, b});
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    r    = '0;
    case (op)
      3'b000: begin p = 64'(sa * sb); r = p[31:0]; end
      3'b001: begin p = 64'(sa * sb); r = p[63:32]; end
      3'b010: begin p = 64'(sa * ub); r = p[63:32]; end
      3'b011: begin p = ua64 * ub64; r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF :
                  (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                  32'($signed(a) / $signed(b));
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a :
                  (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                  32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Per-cycle compare against the reference, then advance the reference.
  always @(negedge clk_i) begin
    bit due_now, quick;
    if (rst_i) begin
      m_pend = 1'b0;
      chk("rst_req_ready", 32'(req_ready_o), 32'(!flush_i));
      chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_wb_data", wb_data_o, 32'd0);
      chk("rst_wb_rd", 32'(wb_rd_addr_o), 32'd0);
    end else begin
      due_now = m_pend && (cyc >= m_due);
      chk("req_ready", 32'(req_ready_o), 32'(!m_pend && !flush_i));
      chk("busy", 32'(busy_o), 32'(m_pend));
      chk("wb_valid", 32'(wb_valid_o), 32'(due_now && (m_rd != 0)));
      if (due_now && (m_rd != 0)) begin
        chk("wb_data", wb_data_o, m_data);
        chk("wb_rd", 32'(wb_rd_addr_o), 32'(m_rd));
      end
      if (flush_i) begin
        m_pend = 1'b0;
      end else if (due_now && ((m_rd == 0) || wb_ready_i)) begin
        m_pend = 1'b0;
      end else if (!m_pend && req_valid_i) begin
        quick  = req_op_i[2] && ((req_rs2_data_i == 0) ||
                 (!req_op_i[0] && req_rs1_data_i == 32'h8000_0000 &&
                  req_rs2_data_i == 32'hFFFF_FFFF));
        m_pend = 1'b1;
        m_due  = cyc + (quick ? 1 : 33);
        m_rd   = req_rd_addr_i;
        m_data = ref_res(req_op_i, req_rs1_data_i, req_rs2_data_i);
      end
    end
  end

  // Issue one op, check latency/result against a literal, optional writeback stall.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input int stall);
    int c0, cv;
    bit seen;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_op_i = op; req_rs1_data_i = a; req_rs2_data_i = b;
    req_rd_addr_i = rd; wb_ready_i = (stall == 0);
    c0 = cyc;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    seen = 1'b0;
    cv = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk_i);
      if (wb_valid_o) begin seen = 1'b1; cv = cyc; end
    end
    chk("latency", 32'(seen ? cv - c0 : -1), 32'(lat));
    chk("result", wb_data_o, exp);
    chk("result_rd", 32'(wb_rd_addr_o), 32'(rd));
    if (stall > 0) begin
      for (int s = 1; s < stall; s++) begin
        @(negedge clk_i);
        chk("stall_valid", 32'(wb_valid_o), 32'd1);
        chk("stall_data", wb_data_o, exp);
        chk("stall_rd", 32'(wb_rd_addr_o), 32'(rd));
        chk("stall_ready", 32'(req_ready_o), 32'd0);
      end
      @(posedge clk_i); #1;
      wb_ready_i = 1'b1;
      @(negedge clk_i);
      chk("stall_release_valid", 32'(wb_valid_o), 32'd1);
    end
    @(negedge clk_i);
    chk("ready_after_wb", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_rs1_data_i = '0;
    req_rs2_data_i = '0; req_rd_addr_i = '0; flush_i = 1'b0; wb_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    run_op(OP_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         33, 0);
    run_op(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  33, 0);
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33, 0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFF,  33, 0);
    run_op(OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'h0000_0001,  33, 0);
    run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000,  5'd6,  32'h4000_0000,  33, 0);
    run_op(OP_MULHSU, 32'h8000_0000,  32'd2,          5'd7,  32'hFFFF_FFFF,  33, 0);
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFD,  33, 0);
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,          5'd9,  32'hFFFF_FFFF,  33, 0);
    run_op(OP_DIVU,   32'd100,        32'd7,          5'd10, 32'd14,         33, 0);
    run_op(OP_REMU,   32'd100,        32'd7,          5'd11, 32'd2,          33, 0);
    run_op(OP_DIV,    32'h8000_0000,  32'd2,          5'd12, 32'hC000_0000,  33, 0);
    run_op(OP_DIV,    32'd5,          32'd0,          5'd13, 32'hFFFF_FFFF,  1,  0);
    run_op(OP_REM,    32'd5,          32'd0,          5'd14, 32'd5,          1,  0);
    run_op(OP_DIVU,   32'd5,          32'd0,          5'd15, 32'hFFFF_FFFF,  1,  0);
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000,  1,  0);
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'd0,          1,  0);

    // writeback backpressure for 5 cycles
    run_op(OP_DIVU,   32'd1000,       32'd10,         5'd18, 32'd100,        33, 5);

    // rd==0: no write, ready again at cycle 34
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_op_i = OP_MUL; req_rs1_data_i = 32'd3; req_rs2_data_i = 32'd3;
    req_rd_addr_i = 5'd0;
    c0 = cyc;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (cyc == c0 + 33) chk("rd0_ready_done", 32'(req_ready_o), 32'd0);
      if (cyc == c0 + 34) begin
        chk("rd0_ready_back", 32'(req_ready_o), 32'd1);
        break;
      end
    end

    // flush at cycle 10 of a DIV
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_op_i = OP_DIV; req_rs1_data_i = 32'd1000; req_rs2_data_i = 32'd3;
    req_rd_addr_i = 5'd19;
    c0 = cyc;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 flush_i = 1'b1;
    chk("flush_cycle", 32'(cyc - c0), 32'd10);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_wb_valid", 32'(wb_valid_o), 32'd0);
    repeat (30) @(negedge clk_i);

    // request together with flush is dropped
    @(posedge clk_i); #1;
    flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = OP_MUL;
    req_rs1_data_i = 32'd9; req_rs2_data_i = 32'd9; req_rd_addr_i = 5'd20;
    @(negedge clk_i);
    chk("flush_req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush_req_busy", 32'(busy_o), 32'd0);

    // asynchronous reset in the middle of a MUL
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_op_i = OP_MUL; req_rs1_data_i = 32'd12345;
    req_rs2_data_i = 32'd678; req_rd_addr_i = 5'd3;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready_o), 32'd1);
    chk("arst_valid", 32'(wb_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_data", wb_data_o, 32'd0);
    chk("arst_rd", 32'(wb_rd_addr_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    run_op(OP_MUL, 32'd12345, 32'd678, 5'd3, 32'd8369910, 33, 0);

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
